// File: rtl/dmem_ws.sv
// ---------------------------------------------------------------------------
// dmem_ws : data memory with a wait-state engine.
//
// Models a slow RAM behind a req/ready handshake. Each access is latched on
// its accept edge and completes WAIT_CYCLES+1 edges later (the accept edge
// counts as the first). Stores commit and loads sample on the edge entering
// DONE. Misaligned word/half accesses are rejected: no array access, rdata=0,
// and misalign pulses together with ready.
//
// Optional build macro: DMEM_WS_B2B_EN
//   defined   : a request seen in DONE is accepted immediately (no bubble)
//   undefined : DONE always returns to IDLE (one bubble cycle per access)
//
// Ports
//   clk      in   1       system clock, rising edge
//   reset    in   1       asynchronous, active-high reset
//   req      in   1       access request, held high until ready
//   we       in   1       1 = store, 0 = load
//   addr     in   ADDR_W  byte address (bits above the index field ignored)
//   wdata    in   32      store data, right-aligned
//   dmtype   in   3       000 word, 001 half s, 010 half u, 011 byte s,
//                         100 byte u, 101..111 word
//   rdata    out  32      registered, extended load result
//   ready    out  1       one-cycle completion pulse
//   misalign out  1       pulses with ready for a rejected access
//   stall    out  1       req & ~ready
//
// The byte lanes live in dmem_ws_lane, one instance per lane. ADDR_W must be
// greater than log2(DEPTH_WORDS)+2.
// ---------------------------------------------------------------------------

// One byte lane of the memory: synchronous write, asynchronous read.
module dmem_ws_lane #(
    parameter int DEPTH = 128,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wbyte,
    output logic [7:0]       rbyte
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[idx] <= wbyte;

    assign rbyte = mem[idx];
endmodule

module dmem_ws #(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        dmtype,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              misalign,
    output logic              stall
);
    localparam int NUM_LANES = 4;
    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

`ifdef DMEM_WS_B2B_EN
    localparam bit B2B_EN = 1'b1;
`else
    localparam bit B2B_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic             we;
        logic [IDX_W-1:0] idx;
        logic [1:0]       boff;
        logic [31:0]      wdata;
        logic [2:0]       dmtype;
    } acc_t;

    state_t state, next_state;
    logic [3:0] cnt, cnt_nxt;
    acc_t acc_in, acc_q, cur;
    logic accept, enter_done;

    logic is_half, is_byte, is_word, h_sgn, b_sgn, mis_cur, mis_q;
    logic [NUM_LANES-1:0]      lane_mask, wr_en;
    logic [NUM_LANES-1:0][7:0] wbyte, rbyte;
    logic [31:0] rword, load_val;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Address bits above the index field alias and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^addr[ADDR_W-1:IDX_W+2];

    assign acc_in = '{we: we, idx: addr[IDX_W+1:2], boff: addr[1:0],
                      wdata: wdata, dmtype: dmtype};

    assign accept = req && (state == S_IDLE || (B2B_EN && state == S_DONE));

    // An access accepted this edge with no wait states completes on the
    // same edge, so it must be served from the live inputs, not acc_q.
    assign cur        = accept ? acc_in : acc_q;
    assign enter_done = (next_state == S_DONE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc_q <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
            if (accept) acc_q <= acc_in;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        case (state)
            S_IDLE, S_DONE: begin
                next_state = S_IDLE;
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        next_state = S_WAIT;
                        cnt_nxt    = WAIT_M1;
                    end else begin
                        next_state = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) next_state = S_DONE;
                else             cnt_nxt    = cnt - 4'd1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready    = (state == S_DONE);
        misalign = (state == S_DONE) && mis_q;
    end

    assign stall = req & ~ready;

    // ---------------- access decode ----------------
    assign is_half = (cur.dmtype == 3'b001) || (cur.dmtype == 3'b010);
    assign is_byte = (cur.dmtype == 3'b011) || (cur.dmtype == 3'b100);
    assign is_word = ~is_half & ~is_byte;
    assign h_sgn   = (cur.dmtype == 3'b001);
    assign b_sgn   = (cur.dmtype == 3'b011);
    assign mis_cur = (is_word && cur.boff != 2'b00) || (is_half && cur.boff[0]);

    always_comb begin
        lane_mask = '0;
        if (is_word)      lane_mask = '1;
        else if (is_half) lane_mask = cur.boff[1] ? 4'b1100 : 4'b0011;
        else              lane_mask[cur.boff] = 1'b1;
    end

    // ---------------- byte lanes ----------------
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        // Replicate narrow store data so every enabled lane sees its byte.
        assign wbyte[l] = is_word ? cur.wdata[8*l +: 8]
                        : is_half ? cur.wdata[8*(l%2) +: 8]
                        :           cur.wdata[7:0];

        // Gated by reset so an access in flight is never committed.
        assign wr_en[l] = enter_done & ~reset & cur.we & ~mis_cur & lane_mask[l];

        dmem_ws_lane #(
            .DEPTH (DEPTH_WORDS),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk   (clk),
            .wr_en (wr_en[l]),
            .idx   (cur.idx),
            .wbyte (wbyte[l]),
            .rbyte (rbyte[l])
        );
    end

    // ---------------- load extraction ----------------
    assign rword = rbyte;

    always_comb begin
        half_sel = cur.boff[1] ? rword[31:16] : rword[15:0];
        byte_sel = rbyte[cur.boff];
        if (is_half)
            load_val = h_sgn ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        else if (is_byte)
            load_val = b_sgn ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        else
            load_val = rword;
    end

    // rdata only changes at a completion; stores leave the last load value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
            mis_q <= 1'b0;
        end else if (enter_done) begin
            mis_q <= mis_cur;
            if (mis_cur)      rdata <= '0;
            else if (!cur.we) rdata <= load_val;
        end
    end
endmodule
